// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader that feeds the 9-bit core's instruction memory.
package loader_pkg;

   // Loader phases: low byte, high byte, start pulse, core running.
   typedef enum logic [1:0] {
      LO    = 2'd0,
      HI    = 2'd1,
      START = 2'd2,
      RUN   = 2'd3
   } load_state_t;

   // Only bit 0 of a high byte carries code; any other set bit is a malformed stream.
   localparam logic [7:0] HI_PAD_MASK = 8'hFE;

   // Machine-code word width of the core.
   localparam int W = 9;

endpackage

// File: rtl/prog_loader.sv
// Boot loader: packs a byte stream into 9-bit words, writes them to consecutive
// instruction-memory addresses, starts the core and waits for it to finish.
module prog_loader
   import loader_pkg::*;
#(
   parameter int D = 12,
   parameter int W = loader_pkg::W
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   input  logic         in_last,
   input  logic         cpu_done,
   output logic         wr_en,
   output logic [D-1:0] wr_addr,
   output logic [W-1:0] wr_data,
   output logic         req,
   output logic         busy,
   output logic [D:0]   prog_len,
   output logic         err
);

   // prog_len value meaning the whole address space has been written.
   localparam logic [D:0] FULL = {1'b1, {D{1'b0}}};

   load_state_t state;
   load_state_t next_state;
   logic [7:0]  lo_byte;
   logic        xfer;

   assign xfer = in_valid && in_ready;

   // Next-state decode; input is accepted only while assembling words.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      case (state)
         LO: begin
            in_ready = 1'b1;
            if (in_valid) begin
               next_state = in_last ? START : HI;
            end else begin
               next_state = LO;
            end
         end
         HI: begin
            in_ready = 1'b1;
            if (in_valid) begin
               next_state = in_last ? START : LO;
            end else begin
               next_state = HI;
            end
         end
         START: begin
            next_state = RUN;
         end
         RUN: begin
            if (cpu_done) begin
               next_state = LO;
            end else begin
               next_state = RUN;
            end
         end
         default: begin
            next_state = LO;
         end
      endcase
   end

   // State, word assembly, length/error bookkeeping and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= LO;
         lo_byte  <= 8'h00;
         prog_len <= {(D+1){1'b0}};
         err      <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= {D{1'b0}};
         wr_data  <= {W{1'b0}};
         req      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state <= next_state;
         wr_en <= 1'b0;
         req   <= 1'b0;
         case (state)
            LO: begin
               if (xfer) begin
                  if (in_last) begin
                     // A stream ending on a low byte leaves half a word: drop it.
                     err <= 1'b1;
                  end else begin
                     lo_byte <= in_data;
                  end
               end
            end
            HI: begin
               if (xfer) begin
                  if ((in_data & HI_PAD_MASK) != 8'h00) begin
                     err <= 1'b1;
                  end else if (prog_len == FULL) begin
                     err <= 1'b1;
                  end else begin
                     wr_en    <= 1'b1;
                     wr_addr  <= prog_len[D-1:0];
                     wr_data  <= W'({in_data[0], lo_byte});
                     prog_len <= prog_len + {{D{1'b0}}, 1'b1};
                  end
               end
            end
            START: begin
               req  <= 1'b1;
               busy <= 1'b1;
            end
            RUN: begin
               if (cpu_done) begin
                  busy     <= 1'b0;
                  prog_len <= {(D+1){1'b0}};
                  err      <= 1'b0;
               end
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: two instances (D=12 and D=2) share one stimulus
// stream; expected writes, lengths, errors and timing come from a word-level model.
module tb_prog_loader;

   localparam int DA = 12;
   localparam int DB = 2;
   localparam int W  = 9;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } wr_t;

   logic clk = 1'b0;
   logic reset, in_valid, in_last, cpu_done;
   logic [7:0] in_data;

   logic          ready_a, wr_en_a, req_a, busy_a, err_a;
   logic [DA-1:0] wr_addr_a;
   logic [W-1:0]  wr_data_a;
   logic [DA:0]   prog_len_a;

   logic          ready_b, wr_en_b, req_b, busy_b, err_b;
   logic [DB-1:0] wr_addr_b;
   logic [W-1:0]  wr_data_b;
   logic [DB:0]   prog_len_b;

   int vectors     = 0;
   int miscompares = 0;
   int ncyc        = 0;

   wr_t        obs_a[$], obs_b[$];
   int         rq_a[$], rq_b[$];
   logic [7:0] bytes_q[$];
   int         xfer_cyc[$];

   prog_loader #(.D(DA), .W(W)) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready_a),
      .in_data(in_data), .in_last(in_last), .cpu_done(cpu_done),
      .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
      .req(req_a), .busy(busy_a), .prog_len(prog_len_a), .err(err_a)
   );

   prog_loader #(.D(DB), .W(W)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready_b),
      .in_data(in_data), .in_last(in_last), .cpu_done(cpu_done),
      .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
      .req(req_b), .busy(busy_b), .prog_len(prog_len_b), .err(err_b)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle index: stable during the low phase, names the current cycle.
   always @(posedge clk) ncyc <= ncyc + 1;

   // Record every write and start pulse of both instances.
   always @(negedge clk) begin
      if (wr_en_a) obs_a.push_back('{addr: int'(wr_addr_a), data: int'(wr_data_a), cyc: ncyc});
      if (wr_en_b) obs_b.push_back('{addr: int'(wr_addr_b), data: int'(wr_data_b), cyc: ncyc});
      if (req_a) rq_a.push_back(ncyc);
      if (req_b) rq_b.push_back(ncyc);
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      obs_a.delete(); obs_b.delete(); rq_a.delete(); rq_b.delete();
   endtask

   // Stream bytes_q, one per cycle with random idle gaps; in_last on the final byte.
   task automatic send_load();
      xfer_cyc.delete();
      for (int i = 0; i < bytes_q.size(); i++) begin
         if ($urandom_range(3) == 0) begin
            in_valid = 1'b0;
            cpu_done = 1'($urandom_range(1));
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = bytes_q[i];
         in_last  = (i == bytes_q.size() - 1);
         cpu_done = 1'($urandom_range(1));
         @(negedge clk);
         check_val("ready_a_load", ready_a, 1);
         check_val("ready_b_load", ready_b, 1);
         xfer_cyc.push_back(ncyc);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Word-level reference: pairs become words unless padded badly or memory is full.
   task automatic check_load(input string nm, input int cap, input wr_t obs[$], input int rq[$],
                             input int plen, input logic e);
      wr_t exp[$];
      wr_t w;
      int  len = 0;
      bit  bad = 1'b0;
      int  n = bytes_q.size();
      for (int i = 0; i + 1 < n; i += 2) begin
         if (bytes_q[i+1][7:1] != 7'd0) bad = 1'b1;
         else if (len == cap) bad = 1'b1;
         else begin
            w.addr = len;
            w.data = int'(bytes_q[i+1][0]) * 256 + int'(bytes_q[i]);
            w.cyc  = xfer_cyc[i+1] + 1;
            exp.push_back(w);
            len++;
         end
      end
      if (n % 2 == 1) bad = 1'b1;
      check_val({nm, "_nwrites"}, obs.size(), exp.size());
      for (int k = 0; k < exp.size() && k < obs.size(); k++) begin
         check_val({nm, "_addr"}, obs[k].addr, exp[k].addr);
         check_val({nm, "_data"}, obs[k].data, exp[k].data);
         check_val({nm, "_wcyc"}, obs[k].cyc, exp[k].cyc);
      end
      check_val({nm, "_nreq"}, rq.size(), 1);
      if (rq.size() > 0) check_val({nm, "_reqcyc"}, rq[0], xfer_cyc[n-1] + 2);
      check_val({nm, "_prog_len"}, plen, len);
      check_val({nm, "_err"}, e, bad);
   endtask

   // Core running: inputs are back-pressured, then cpu_done releases the loader.
   task automatic run_phase();
      @(posedge clk); #1;
      cpu_done = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom_range(1));
      repeat (2 + $urandom_range(3)) begin
         @(negedge clk);
         check_val("ready_a_run", ready_a, 0);
         check_val("ready_b_run", ready_b, 0);
         check_val("busy_a_run", busy_a, 1);
         check_val("busy_b_run", busy_b, 1);
         @(posedge clk); #1;
      end
      check_load("a", 1 << DA, obs_a, rq_a, int'(prog_len_a), err_a);
      check_load("b", 1 << DB, obs_b, rq_b, int'(prog_len_b), err_b);
      cpu_done = 1'b1;
      @(posedge clk); #1;
      cpu_done = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      check_val("busy_a_done", busy_a, 0);
      check_val("ready_a_done", ready_a, 1);
      check_val("len_a_done", prog_len_a, 0);
      check_val("err_a_done", err_a, 0);
      check_val("busy_b_done", busy_b, 0);
      check_val("ready_b_done", ready_b, 1);
      check_val("len_b_done", prog_len_b, 0);
      check_val("err_b_done", err_b, 0);
      clear_obs();
      @(posedge clk); #1;
   endtask

   task automatic load_and_run();
      send_load();
      run_phase();
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'h00;
      cpu_done = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_wr_en", wr_en_a, 0);
      check_val("rst_wr_addr", wr_addr_a, 0);
      check_val("rst_wr_data", wr_data_a, 0);
      check_val("rst_req", req_a, 0);
      check_val("rst_busy", busy_a, 0);
      check_val("rst_prog_len", prog_len_a, 0);
      check_val("rst_err", err_a, 0);
      reset = 1'b0;
      @(negedge clk);
      check_val("rst_ready", ready_a, 1);
      @(posedge clk); #1;
      clear_obs();

      // Three-word load.
      bytes_q = '{8'h34, 8'h01, 8'hAB, 8'h00, 8'hFF, 8'h01};
      load_and_run();
      // Bad pad on word 1.
      bytes_q = '{8'h34, 8'h01, 8'hAB, 8'h03, 8'hFF, 8'h01};
      load_and_run();
      // Odd stream: last on a low byte after two words.
      bytes_q = '{8'h11, 8'h00, 8'h22, 8'h01, 8'h33};
      load_and_run();
      // Empty program.
      bytes_q = '{8'h5A};
      load_and_run();
      // Five words: overflows the D=2 instance.
      bytes_q = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h03, 8'h00, 8'h04, 8'h01, 8'h05, 8'h00};
      load_and_run();

      // Reset mid-word, then a one-word load.
      in_valid = 1'b1; in_data = 8'h77; in_last = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_val("midrst_len", prog_len_a, 0);
      check_val("midrst_ready", ready_a, 1);
      @(posedge clk); #1;
      clear_obs();
      bytes_q = '{8'h55, 8'h00};
      load_and_run();

      // Random loads.
      for (int r = 0; r < 25; r++) begin
         int n;
         n = $urandom_range(1, 14);
         bytes_q.delete();
         for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) bytes_q.push_back(8'($urandom));
            else if ($urandom_range(5) == 0) bytes_q.push_back(8'($urandom_range(2, 255)));
            else bytes_q.push_back(8'($urandom_range(1)));
         end
         load_and_run();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
